// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin, burst-locked arbiter sharing one FIFO write
// port among NUM_REQ valid/ready requesters.
// A grant is held until the requester flags last or MAX_BURST beats are written.
// Optional feature macro: FIFO_ARB_SRC_TAG_EN prepends the granted source index
// to the FIFO payload (FIFO_W = DATA_WIDTH + $clog2(NUM_REQ)).
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8,
  localparam int IDX_W     = $clog2(NUM_REQ),
`ifdef FIFO_ARB_SRC_TAG_EN
  localparam int FIFO_W    = DATA_WIDTH + $clog2(NUM_REQ)
`else
  localparam int FIFO_W    = DATA_WIDTH
`endif
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          fifo_w_en_o,
  output logic [FIFO_W-1:0]             fifo_data_o,
  input  logic                          fifo_full_i
);

  localparam int                 CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]   MAX_CNT  = CNT_W'(MAX_BURST);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NUM_REQ-1:0]    r_grant;
  logic [IDX_W-1:0]      r_gidx;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [CNT_W-1:0]      r_beat_cnt;

  logic                  w_sel_found;
  logic [IDX_W-1:0]      w_sel_idx;
  logic [IDX_W-1:0]      w_cand_idx;
  logic                  w_g_valid;
  logic                  w_g_last;
  logic [DATA_WIDTH-1:0] w_g_data;
  logic                  w_beat;
  logic                  w_burst_end;
  logic                  w_pending;
  logic [CNT_W-1:0]      w_cnt_inc;

  assign grant_o   = r_grant;
  assign busy_o    = (r_state == ST_BURST);
  assign w_cnt_inc = r_beat_cnt + CNT_W'(1);
  assign w_g_valid = req_valid_i[r_gidx];
  assign w_g_last  = req_last_i[r_gidx];
  // The granted requester's valid on the ending edge is the beat just consumed,
  // so only the other requesters count as pending work after a burst.
  assign w_pending = |(req_valid_i & ~r_grant);

  // Round-robin pick: first valid index starting just after the last owner.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_cand_idx  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand_idx = IDX_W'((int'(r_rr_ptr) + i) % NUM_REQ);
      if (!w_sel_found && req_valid_i[w_cand_idx]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_cand_idx;
      end else begin
        w_sel_idx   = w_sel_idx;
      end
    end
  end

  // Payload mux for the currently granted lane.
  always_comb begin
    w_g_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_gidx == IDX_W'(k)) begin
        w_g_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        w_g_data = w_g_data;
      end
    end
  end

  // Next-state and handshake outputs; ready and write enable follow full combinationally.
  always_comb begin
    w_state_nxt = r_state;
    req_ready_o = '0;
    fifo_w_en_o = 1'b0;
    fifo_data_o = '0;
    w_beat      = 1'b0;
    w_burst_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req_valid_i) begin
          w_state_nxt = ST_ARB;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ARB: begin
        if (w_sel_found) begin
          w_state_nxt = ST_BURST;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BURST: begin
        req_ready_o = fifo_full_i ? '0 : r_grant;
        w_beat      = w_g_valid & ~fifo_full_i;
        fifo_w_en_o = w_beat;
`ifdef FIFO_ARB_SRC_TAG_EN
        fifo_data_o = {r_gidx, w_g_data};
`else
        fifo_data_o = w_g_data;
`endif
        w_burst_end = w_beat & (w_g_last | (w_cnt_inc == MAX_CNT));
        if (w_burst_end) begin
          w_state_nxt = w_pending ? ST_ARB : ST_IDLE;
        end else begin
          w_state_nxt = ST_BURST;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant, owner index, round-robin pointer and saturating beat counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_grant    <= '0;
      r_gidx     <= '0;
      r_rr_ptr   <= IDX_W'(NUM_REQ - 1);
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_ARB: begin
          r_beat_cnt <= '0;
          if (w_sel_found) begin
            r_grant <= ONE_HOT0 << w_sel_idx;
            r_gidx  <= w_sel_idx;
          end
        end
        ST_BURST: begin
          if (w_beat && (r_beat_cnt != MAX_CNT)) begin
            r_beat_cnt <= w_cnt_inc;
          end
          if (w_burst_end) begin
            r_rr_ptr <= r_gidx;
            r_grant  <= '0;
          end
        end
        default: begin
          r_grant <= r_grant;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter (NUM_REQ=4, DATA_WIDTH=8,
// MAX_BURST=8). The source-tag vector runs only when FIFO_ARB_SRC_TAG_EN is set.
module tb_fifo_write_arbiter;

`ifdef FIFO_ARB_SRC_TAG_EN
  localparam int FW = 10;
`else
  localparam int FW = 8;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  valid;
  logic [31:0] data;
  logic [3:0]  last;
  logic [3:0]  ready;
  logic [3:0]  grant;
  logic        busy;
  logic        wen;
  logic [FW-1:0] fdata;
  logic        full;

  int checks = 0;
  int errors = 0;

  fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(valid), .req_data_i(data), .req_last_i(last),
    .req_ready_o(ready), .grant_o(grant), .busy_o(busy),
    .fifo_w_en_o(wen), .fifo_data_o(fdata), .fifo_full_i(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic lane(input int k, input logic [7:0] v);
    data[k*8 +: 8] = v;
  endtask

  initial begin
    rst = 1'b1; valid = 4'h0; data = 32'h0; last = 4'h0; full = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_wen",   32'(wen),   32'h0);
    chk("rst_data",  32'(fdata), 32'h0);
    #12 rst = 1'b0;
    cyc();

    // Fairness: all valid, 1-beat bursts -> grants 0,1,2,3,0 with an ARB gap.
    valid = 4'hF; last = 4'hF; data = 32'h44332211;
    #1 chk("fair_idle_grant", 32'(grant), 32'h0);
    for (int k = 0; k < 5; k++) begin
      cyc(); #1;
      chk("fair_arb_busy", 32'(busy), 32'h0);
      chk("fair_arb_wen",  32'(wen),  32'h0);
      cyc(); #1;
      chk("fair_grant", 32'(grant), 32'(4'b0001 << (k % 4)));
      chk("fair_wen",   32'(wen),   32'h1);
      chk("fair_data",  32'(fdata), 32'(8'h11 * (k % 4 + 1)));
    end
    cyc(); valid = 4'h0; last = 4'h0;
    #1 chk("fair_end_arb_busy", 32'(busy), 32'h0);
    cyc(); #1;
    chk("fair_end_idle_grant", 32'(grant), 32'h0);

    // Single requester 2: three beats, last on the third.
    valid = 4'b0100; lane(2, 8'h51);
    #1 chk("single_T_busy", 32'(busy), 32'h0);
    cyc(); #1;
    chk("single_T1_grant", 32'(grant), 32'h0);
    chk("single_T1_wen",   32'(wen),   32'h0);
    cyc(); #1;
    chk("single_T2_grant", 32'(grant), 32'h4);
    chk("single_T2_ready", 32'(ready), 32'h4);
    chk("single_b1_wen",   32'(wen),   32'h1);
    chk("single_b1_data",  32'(fdata), 32'h51);
    cyc(); lane(2, 8'h52);
    #1 chk("single_b2_wen", 32'(wen), 32'h1);
    chk("single_b2_data", 32'(fdata), 32'h52);
    cyc(); lane(2, 8'h53); last = 4'b0100;
    #1 chk("single_b3_wen", 32'(wen), 32'h1);
    chk("single_b3_data", 32'(fdata), 32'h53);
    cyc(); valid = 4'h0; last = 4'h0;
    #1 chk("single_idle_grant", 32'(grant), 32'h0);
    chk("single_idle_busy", 32'(busy), 32'h0);
    chk("single_idle_wen",  32'(wen),  32'h0);

    // Burst cap: requester 1 never asserts last; requester 2 also waiting.
    valid = 4'b0110; lane(1, 8'h30); lane(2, 8'hC2);
    #1;
    cyc();
    for (int i = 0; i < 8; i++) begin
      cyc(); lane(1, 8'(8'h30 + i));
      #1 chk("cap_grant", 32'(grant), 32'h2);
      chk("cap_wen",   32'(wen),   32'h1);
      chk("cap_data",  32'(fdata), 32'(8'h30 + i));
      chk("cap_ready", 32'(ready), 32'h2);
    end
    cyc(); #1;
    chk("cap_gap_grant", 32'(grant), 32'h0);
    chk("cap_gap_wen",   32'(wen),   32'h0);
    cyc(); last = 4'b0100;
    #1 chk("cap_next_grant", 32'(grant), 32'h4);
    chk("cap_next_data", 32'(fdata), 32'hC2);
    chk("cap_next_wen",  32'(wen),   32'h1);
    cyc(); valid = 4'h0; last = 4'h0;
    #1 chk("cap_arb_busy", 32'(busy), 32'h0);
    cyc(); #1;
    chk("cap_idle_grant", 32'(grant), 32'h0);

    // Back-pressure: full held 3 cycles mid-burst on requester 3.
    valid = 4'b1000; lane(3, 8'hD0);
    #1;
    cyc();
    cyc(); #1;
    chk("bp_grant", 32'(grant), 32'h8);
    chk("bp_b1_data", 32'(fdata), 32'hD0);
    chk("bp_b1_wen", 32'(wen), 32'h1);
    cyc(); lane(3, 8'hD1);
    #1 chk("bp_b2_data", 32'(fdata), 32'hD1);
    for (int i = 0; i < 3; i++) begin
      cyc(); lane(3, 8'hD2); full = 1'b1;
      #1 chk("bp_full_wen", 32'(wen), 32'h0);
      chk("bp_full_ready", 32'(ready), 32'h0);
      chk("bp_full_grant", 32'(grant), 32'h8);
      chk("bp_full_busy",  32'(busy),  32'h1);
      chk("bp_full_cnt",   32'(dut.r_beat_cnt), 32'h2);
    end
    cyc(); full = 1'b0;
    #1 chk("bp_b3_wen", 32'(wen), 32'h1);
    chk("bp_b3_data", 32'(fdata), 32'hD2);
    chk("bp_b3_cnt",  32'(dut.r_beat_cnt), 32'h2);
    cyc(); lane(3, 8'hD3); last = 4'b1000;
    #1 chk("bp_b4_data", 32'(fdata), 32'hD3);
    chk("bp_b4_cnt", 32'(dut.r_beat_cnt), 32'h3);
    cyc(); valid = 4'h0; last = 4'h0;
    #1 chk("bp_idle_busy", 32'(busy), 32'h0);

    // Async reset during beat 4 of a requester-2 burst.
    valid = 4'b0100; lane(2, 8'hE0); lane(0, 8'h0F);
    #1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      cyc(); lane(2, 8'(8'hE0 + i));
      #1 chk("ar_beat_wen", 32'(wen), 32'h1);
    end
    rst = 1'b1;
    #1;
    chk("ar_grant", 32'(grant), 32'h0);
    chk("ar_busy",  32'(busy),  32'h0);
    chk("ar_ready", 32'(ready), 32'h0);
    chk("ar_wen",   32'(wen),   32'h0);
    chk("ar_data",  32'(fdata), 32'h0);
    chk("ar_cnt",   32'(dut.r_beat_cnt), 32'h0);
    #1 valid = 4'b0101;
    #1 rst = 1'b0;
    cyc(); #1;
    chk("ar_rel_arb_grant", 32'(grant), 32'h0);
    cyc(); #1;
    chk("ar_first_grant", 32'(grant), 32'h1);
    chk("ar_first_data",  32'(fdata), 32'h0F);

`ifdef FIFO_ARB_SRC_TAG_EN
    // Source tag: requester 3 writes 0xA5 -> {2'b11, 8'hA5}.
    rst = 1'b1; valid = 4'h0; last = 4'h0;
    #1 rst = 1'b0;
    valid = 4'b1000; lane(3, 8'hA5); last = 4'b1000;
    cyc();
    cyc(); #1;
    chk("tag_data", 32'(fdata), 32'h3A5);
    chk("tag_wen",  32'(wen),   32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
